// File: rtl/rf_pkg.sv
// Shared constants, FSM states and op encoding for the register-file access arbiter.
package rf_pkg;
    localparam int NENT = 5;
    localparam int IDXW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ERR   = 2'd2
    } state_t;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;
endpackage

// File: rtl/rf_access_arbiter_rr.sv
// Round-robin pick: first valid requester after i_last_gnt, wrapping; combinational, 0 cycles.
// No backpressure of its own; holds i_last_gnt on the output when nothing is valid.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [$clog2(NREQ)-1:0] i_last_gnt,
    input  logic [NREQ-1:0]         i_valid,
    output logic [$clog2(NREQ)-1:0] o_gnt_idx
);
    localparam int GW = $clog2(NREQ);

    int w_dist;
    int w_best;

    always_comb begin
        o_gnt_idx = i_last_gnt;
        w_best    = NREQ;
        w_dist    = 0;
        for (int c = 0; c < NREQ; c++) begin
            // Distance 0 is the requester right after the last grantee.
            w_dist = (c + NREQ - 1 - int'(i_last_gnt)) % NREQ;
            if (i_valid[c] && (w_dist < w_best)) begin
                w_best    = w_dist;
                o_gnt_idx = GW'(c);
            end
        end
    end
endmodule

// File: rtl/rf_access_arbiter.sv
// Grants one requester per cycle to the register-file array and decodes its op into one-hot strobes.
// Latency: accepted at t, strobes/gnt_id/done at t+1; req_ready is the only backpressure, zero once halted in ERR.
module rf_access_arbiter #(
    parameter int NREQ     = 2,
    parameter int NENT     = rf_pkg::NENT,
    parameter int IDXW     = rf_pkg::IDXW,
    parameter int MAX_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ-1:0]          req_wr,
    input  logic [NREQ*IDXW-1:0]     req_idx_a,
    input  logic [NREQ*IDXW-1:0]     req_idx_b,
    output logic [NREQ-1:0]          req_ready,
    output logic [NENT-1:0]          rd_enA,
    output logic [NENT-1:0]          rd_enB,
    output logic [NENT-1:0]          wr_en,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic                     done,
    output logic                     ERROR
);
    import rf_pkg::*;

    localparam int GW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GW-1:0]   r_last_gnt;
    logic [GW-1:0]   r_gnt_id;
    logic [HW-1:0]   r_hold_cnt;
    logic [HW-1:0]   w_hold_nxt;
    logic [NENT-1:0] r_rd_a;
    logic [NENT-1:0] r_rd_b;
    logic [NENT-1:0] r_wr;
    logic            r_done;
    logic            r_error;

    logic [GW-1:0]   w_rr_idx;
    logic [GW-1:0]   w_gnt_idx;
    logic            w_lock_keep;
    logic            w_any;
    logic            w_bad;
    logic            w_is_wr;
    logic [IDXW-1:0] w_idx_a;
    logic [IDXW-1:0] w_idx_b;
    logic [IDXW-1:0] w_ia [NREQ];
    logic [IDXW-1:0] w_ib [NREQ];

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .i_last_gnt (r_last_gnt),
        .i_valid    (req_valid),
        .o_gnt_idx  (w_rr_idx)
    );

    always_comb begin
        for (int c = 0; c < NREQ; c++) begin
            w_ia[c] = req_idx_a[c*IDXW +: IDXW];
            w_ib[c] = req_idx_b[c*IDXW +: IDXW];
        end
    end

    always_comb begin
        // A non-zero hold count means r_last_gnt was granted in the previous cycle.
        w_lock_keep = (r_hold_cnt != '0) && req_valid[r_last_gnt] && req_lock[r_last_gnt]
                      && (r_hold_cnt < HW'(MAX_HOLD));
        w_any       = (|req_valid) && (r_state != ERR);
        w_gnt_idx   = w_lock_keep ? r_last_gnt : w_rr_idx;
        w_idx_a     = w_ia[w_gnt_idx];
        w_idx_b     = w_ib[w_gnt_idx];
        w_is_wr     = req_wr[w_gnt_idx];
        w_bad       = (int'(w_idx_a) >= NENT) || ((w_is_wr == OP_RD) && (int'(w_idx_b) >= NENT));

        req_ready = '0;
        if (w_any) begin
            req_ready[w_gnt_idx] = 1'b1;
        end

        w_hold_nxt = '0;
        if (w_any) begin
            if ((r_hold_cnt != '0) && (w_gnt_idx == r_last_gnt)) begin
                w_hold_nxt = (r_hold_cnt < HW'(MAX_HOLD)) ? r_hold_cnt + HW'(1) : r_hold_cnt;
            end else begin
                w_hold_nxt = HW'(1);
            end
        end

        w_state_nxt = r_state;
        case (r_state)
            IDLE, ISSUE: begin
                if (w_any && w_bad) begin
                    w_state_nxt = ERR;
                end else if (w_any) begin
                    w_state_nxt = ISSUE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ERR:     w_state_nxt = ERR;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last_gnt <= GW'(NREQ - 1);
            r_hold_cnt <= '0;
            r_gnt_id   <= '0;
            r_rd_a     <= '0;
            r_rd_b     <= '0;
            r_wr       <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_rd_a     <= '0;
            r_rd_b     <= '0;
            r_wr       <= '0;
            r_done     <= 1'b0;
            r_error    <= r_error | (w_any & w_bad);
            if (w_any) begin
                r_last_gnt <= w_gnt_idx;
                if (!w_bad) begin
                    r_done   <= 1'b1;
                    r_gnt_id <= w_gnt_idx;
                    if (w_is_wr == OP_WR) begin
                        r_wr <= NENT'(1) << w_idx_a;
                    end else begin
                        r_rd_a <= NENT'(1) << w_idx_a;
                        r_rd_b <= NENT'(1) << w_idx_b;
                    end
                end
            end
        end
    end

    assign rd_enA = r_rd_a;
    assign rd_enB = r_rd_b;
    assign wr_en  = r_wr;
    assign gnt_id = r_gnt_id;
    assign done   = r_done;
    assign ERROR  = r_error;
endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed scenarios plus randomized traffic checked against a queue-free behavioural arbiter model.
module tb_rf_access_arbiter;
    localparam int NREQ     = 2;
    localparam int NENT     = 5;
    localparam int IDXW     = 3;
    localparam int MAX_HOLD = 4;
    localparam int GW       = $clog2(NREQ);

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NREQ-1:0]         req_valid, req_lock, req_wr, req_ready;
    logic [NREQ*IDXW-1:0]    req_idx_a, req_idx_b;
    logic [NENT-1:0]         rd_enA, rd_enB, wr_en;
    logic [GW-1:0]           gnt_id;
    logic                    done, ERROR;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int              m_last, m_prev, m_hold, m_gnt;
    bit              m_err;
    logic [NREQ-1:0] e_ready;
    logic [NENT-1:0] e_rda, e_rdb, e_wr;
    logic            e_done;

    rf_access_arbiter #(.NREQ(NREQ), .NENT(NENT), .IDXW(IDXW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_lock(req_lock), .req_wr(req_wr),
        .req_idx_a(req_idx_a), .req_idx_b(req_idx_b), .req_ready(req_ready),
        .rd_enA(rd_enA), .rd_enB(rd_enB), .wr_en(wr_en),
        .gnt_id(gnt_id), .done(done), .ERROR(ERROR)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic clear_reqs();
        req_valid = '0; req_lock = '0; req_wr = '0; req_idx_a = '0; req_idx_b = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic w,
                           input int a, input int b);
        req_valid[i] = v;
        req_lock[i]  = l;
        req_wr[i]    = w;
        req_idx_a[i*IDXW +: IDXW] = IDXW'(a);
        req_idx_b[i*IDXW +: IDXW] = IDXW'(b);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_reqs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic model_reset();
        m_last = NREQ - 1; m_prev = -1; m_hold = 0; m_gnt = 0; m_err = 0;
    endtask

    // One arbitration cycle from the rules: lock holder if allowed, else first valid after last grant.
    task automatic model_step();
        int g, ia, ib;
        e_ready = '0; e_rda = '0; e_rdb = '0; e_wr = '0; e_done = 1'b0;
        if (!m_err && (req_valid != '0)) begin
            g = -1;
            if (m_prev >= 0 && req_valid[m_prev] && req_lock[m_prev] && m_hold < MAX_HOLD) begin
                g = m_prev;
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (m_last + k) % NREQ;
                    if (g < 0 && req_valid[c]) g = c;
                end
            end
            e_ready[g] = 1'b1;
            ia = int'(req_idx_a[g*IDXW +: IDXW]);
            ib = int'(req_idx_b[g*IDXW +: IDXW]);
            if (ia >= NENT || (!req_wr[g] && ib >= NENT)) begin
                m_err = 1;
            end else begin
                e_done = 1'b1;
                m_gnt  = g;
                if (req_wr[g]) e_wr[ia] = 1'b1;
                else begin
                    e_rda[ia] = 1'b1;
                    e_rdb[ib] = 1'b1;
                end
            end
            m_hold = (g == m_prev) ? ((m_hold < MAX_HOLD) ? m_hold + 1 : MAX_HOLD) : 1;
            m_prev = g;
            m_last = g;
        end else begin
            m_prev = -1;
            m_hold = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_reqs();
        @(posedge clk); #1;
        checks++; if ({rd_enA, rd_enB, wr_en} !== '0) begin errors++; $display("FAIL reset_strobes: got %b expected 0", {rd_enA, rd_enB, wr_en}); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (ERROR !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", ERROR); end
        checks++; if (gnt_id !== '0) begin errors++; $display("FAIL reset_gnt_id: got %0d expected 0", gnt_id); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        do_reset();
        set_req(0, 1, 0, 1, 3, 0);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        checks++; if (wr_en !== 5'b01000) begin errors++; $display("FAIL single_wr_en: got %b expected 01000", wr_en); end
        checks++; if ({rd_enA, rd_enB} !== '0) begin errors++; $display("FAIL single_rd: got %b expected 0", {rd_enA, rd_enB}); end
        checks++; if (done !== 1'b1 || gnt_id !== 1'b0) begin errors++; $display("FAIL single_done_gnt: got done=%b gnt=%0d expected done=1 gnt=0", done, gnt_id); end
        @(negedge clk);
        clear_reqs();
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || wr_en !== '0) begin errors++; $display("FAIL single_pulse: got done=%b wr=%b expected 0", done, wr_en); end
        @(negedge clk);
    endtask

    task automatic test_alternate();
        logic [NREQ-1:0] exp_oh;
        logic [3*NENT-1:0] exp_str;
        do_reset();
        set_req(0, 1, 0, 0, 1, 2);
        set_req(1, 1, 0, 1, 4, 0);
        for (int i = 0; i < 4; i++) begin
            exp_oh  = NREQ'(1) << (i % 2);
            exp_str = (i % 2 == 0) ? {5'b00010, 5'b00100, 5'b00000} : {5'b00000, 5'b00000, 5'b10000};
            #1;
            checks++; if (req_ready !== exp_oh) begin errors++; $display("FAIL alt_ready[%0d]: got %b expected %b", i, req_ready, exp_oh); end
            @(posedge clk); #1;
            checks++; if ({rd_enA, rd_enB, wr_en} !== exp_str || done !== 1'b1 || gnt_id !== GW'(i % 2)) begin
                errors++; $display("FAIL alt_out[%0d]: got str=%b done=%b gnt=%0d expected str=%b done=1 gnt=%0d",
                                   i, {rd_enA, rd_enB, wr_en}, done, gnt_id, exp_str, i % 2);
            end
            @(negedge clk);
        end
        clear_reqs();
    endtask

    task automatic test_lock();
        int exp_g;
        do_reset();
        set_req(0, 1, 0, 1, 1, 0);
        @(posedge clk);
        @(negedge clk);
        set_req(1, 1, 1, 0, 2, 3);
        for (int i = 0; i < 5; i++) begin
            exp_g = (i < 4) ? 1 : 0;
            #1;
            checks++; if (req_ready !== NREQ'(1 << exp_g)) begin errors++; $display("FAIL lock_ready[%0d]: got %b expected grant %0d", i, req_ready, exp_g); end
            @(posedge clk); #1;
            checks++; if (gnt_id !== GW'(exp_g) || done !== 1'b1) begin errors++; $display("FAIL lock_gnt[%0d]: got gnt=%0d done=%b expected gnt=%0d done=1", i, gnt_id, done, exp_g); end
            @(negedge clk);
        end
        clear_reqs();
    endtask

    task automatic test_same_idx();
        do_reset();
        set_req(0, 1, 0, 0, 0, 0);
        @(posedge clk); #1;
        checks++; if (rd_enA !== 5'b00001 || rd_enB !== 5'b00001 || wr_en !== '0) begin
            errors++; $display("FAIL same_idx: got A=%b B=%b W=%b expected A=00001 B=00001 W=0", rd_enA, rd_enB, wr_en);
        end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_error();
        do_reset();
        set_req(1, 1, 0, 1, 6, 0);
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL err_accept: got %b expected 10", req_ready); end
        @(posedge clk); #1;
        checks++; if (ERROR !== 1'b1 || done !== 1'b0 || {rd_enA, rd_enB, wr_en} !== '0) begin
            errors++; $display("FAIL err_set: got err=%b done=%b str=%b expected err=1 done=0 str=0", ERROR, done, {rd_enA, rd_enB, wr_en});
        end
        @(negedge clk);
        set_req(0, 1, 0, 1, 2, 0);
        set_req(1, 1, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (req_ready !== '0) begin errors++; $display("FAIL err_ready[%0d]: got %b expected 00", i, req_ready); end
            @(posedge clk); #1;
            checks++; if (ERROR !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL err_sticky[%0d]: got err=%b done=%b expected err=1 done=0", i, ERROR, done); end
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (ERROR !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", ERROR); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL err_restart_ready: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        checks++; if (gnt_id !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL err_restart: got gnt=%0d done=%b expected gnt=0 done=1", gnt_id, done); end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_req(0, 1, 0, 1, 1, 0);
        @(posedge clk);
        @(negedge clk);
        set_req(1, 1, 1, 0, 2, 3);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if ({rd_enA, rd_enB, wr_en} !== '0 || done !== 1'b0 || gnt_id !== '0) begin
            errors++; $display("FAIL mid_reset: got str=%b done=%b gnt=%0d expected all 0", {rd_enA, rd_enB, wr_en}, done, gnt_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_restart_ready: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        checks++; if (gnt_id !== 1'b0 || wr_en !== 5'b00010) begin errors++; $display("FAIL mid_restart: got gnt=%0d wr=%b expected gnt=0 wr=00010", gnt_id, wr_en); end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_random();
        int r;
        do_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            rst_n = !((r == 0) || (m_err && r < 20));
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 59) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4),
                        ($urandom_range(0, 59) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4));
            end
            model_step();
            if (!rst_n) begin
                model_reset();
                e_rda = '0; e_rdb = '0; e_wr = '0; e_done = 1'b0;
            end
            #1;
            checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, req_ready, e_ready); end
            @(posedge clk); #1;
            checks++; if ({rd_enA, rd_enB, wr_en, done, ERROR, gnt_id} !== {e_rda, e_rdb, e_wr, e_done, m_err, GW'(m_gnt)}) begin
                errors++; $display("FAIL rand_out[%0d]: got A=%b B=%b W=%b d=%b e=%b g=%0d expected A=%b B=%b W=%b d=%b e=%b g=%0d",
                                   n, rd_enA, rd_enB, wr_en, done, ERROR, gnt_id, e_rda, e_rdb, e_wr, e_done, m_err, m_gnt);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        clear_reqs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_reqs();
        @(negedge clk);
        test_reset();
        test_single_write();
        test_alternate();
        test_lock();
        test_same_idx();
        test_error();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rf_access_arbiter.md
# rf_access_arbiter

Shares the 5-entry register-file array between NREQ requesters. Each cycle it grants at most one requester (round-robin, with bounded lock), decodes the granted request into registered one-hot `rd_enA`/`rd_enB`/`wr_en` strobes for the array, and pulses `done`. A request that addresses a nonexistent entry halts the block with a sticky `ERROR`. It replaces free-running enable sequencing whenever more than one agent needs the array.

## Interface
- `NREQ`, 2: number of requesters (2..4).
- `NENT`, 5: number of array entries; width of each enable bus.
- `IDXW`, 3: entry index width.
- `MAX_HOLD`, 4: maximum consecutive grants to one locking requester.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_lock` in NREQ: requester asks to keep the grant next cycle.
- `req_wr` in NREQ: 1 = write of entry `idx_a`; 0 = dual read of `idx_a` (port A) and `idx_b` (port B).
- `req_idx_a` in NREQ*IDXW: packed, requester i at [i*IDXW +: IDXW].
- `req_idx_b` in NREQ*IDXW: packed, same layout; ignored for writes.
- `req_ready` out NREQ: combinational grant, one-hot or zero; a request is accepted when `req_valid[i] & req_ready[i]`.
- `rd_enA`, `rd_enB`, `wr_en` out NENT each: registered one-hot (or zero) strobes.
- `gnt_id` out $clog2(NREQ): registered index of the requester whose op is on the strobes.
- `done` out 1: registered, one pulse per issued op.
- `ERROR` out 1: registered, sticky.

## Operation
- States: IDLE (no valid requests), ISSUE (granting), ERR (halted).
- IDLE -> ISSUE when any `req_valid`. ISSUE -> IDLE when a cycle has no valid request. Any state -> ERR on accepting an invalid request. ERR is left only by reset.
- Arbitration: priority starts at `last_gnt + 1` mod NREQ. After reset, `last_gnt` = NREQ-1, so requester 0 wins first.
- Lock: if the previous cycle's grantee has `req_valid & req_lock`, it keeps the grant while `hold_cnt < MAX_HOLD`. `hold_cnt` counts consecutive grants to the same requester, saturates at MAX_HOLD, and clears on a grant to a different requester.
- Forced rotation: at MAX_HOLD, the grant moves to the next valid requester. If no other requester is valid, the lock holder may continue.
- Decode: a write sets `wr_en[idx_a]`. A read sets `rd_enA[idx_a]` and `rd_enB[idx_b]`; `idx_a == idx_b` is legal, and both ports assert the same bit.
- Invalid request: `idx_a >= NENT`, or `idx_b >= NENT` on a read. The block accepts it (ready = 1), drives no strobes and no `done`, sets `ERROR` at the next edge and enters ERR.
- In ERR: `req_ready` = 0, all strobes 0, `done` = 0, `ERROR` = 1.
- Reset values: all strobes 0, `done` 0, `ERROR` 0, `gnt_id` 0, state IDLE, `hold_cnt` 0.

## Timing
- Request accepted in cycle t; strobes, `gnt_id` and `done` are valid during t+1 for exactly one cycle.
- Throughput: one op per cycle; back-to-back grants produce back-to-back strobes.
- `req_ready` depends combinationally on `req_valid`/`req_lock` and registered state only; it never depends on index values.
- Reset asserted mid-burst: strobes go to 0 at the next edge, any in-flight op is dropped, and arbitration restarts at requester 0.

## Structure
- Package `rf_pkg`: `NENT`, `IDXW`, state enum {IDLE, ISSUE, ERR}, op encoding (`OP_RD` = 0, `OP_WR` = 1).
- Sub-module `rr_arbiter`: NREQ-wide round-robin pick taking `last_gnt` and a valid mask. The lock/hold logic stays in the top module.

## Test plan
- Reset, then requester 0 writes idx 3 -> `wr_en` = 5'b01000 and `done` = 1 one cycle later, `gnt_id` = 0; other strobes 0.
- Both requesters valid, no lock, 4 cycles (0: read 1/2, 1: write 4) -> grants alternate 0,1,0,1. Strobes alternate: `rd_enA` = 00010 with `rd_enB` = 00100, then `wr_en` = 10000.
- Requester 1 locks with requester 0 also valid -> 4 consecutive grants to 1, then grant to 0 on the 5th cycle.
- Requester 0 reads idx_a = idx_b = 0 -> `rd_enA` = `rd_enB` = 00001.
- Requester 1 writes idx 6 -> no strobes, `ERROR` = 1 next cycle; `req_ready` = 0 for all subsequent valid requests until `rst_n` is low at a clock edge.
- Reset held low during a locked burst -> strobes 0 at the next edge; after release, requester 0 is granted first.
